// File: rtl/lcg_stim_gen_if.sv
// -----------------------------------------------------------------------------
// lcg_stim_gen_if
//   Valid/ready stimulus stream from lcg_stim_gen to whatever consumes the
//   generated vectors (normally the DUT in_flat input of a fuzz harness).
//
//   out_valid  producer -> consumer  out_vec holds a complete vector
//   out_ready  consumer -> producer  consumer accepts out_vec this cycle
//   out_vec    producer -> consumer  OUT_W-bit stimulus vector
//
//   master : the generator side
//   slave  : the consumer side
// -----------------------------------------------------------------------------
interface lcg_stim_gen_if #(
  parameter int OUT_W = 260
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_vec;

  modport master (
    output out_valid,
    output out_vec,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_vec,
    output out_ready
  );
endinterface : lcg_stim_gen_if

// File: rtl/lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// lcg_stim_gen
//   Fills an OUT_W-bit stimulus vector one 32-bit word per cycle, least
//   significant word first, from the LCG x' = x*32'h41C64E6D + 32'h3039, and
//   presents each complete vector on a valid/ready stream. A run produces
//   cfg_cycles vectors (0 = unbounded) in one of three modes:
//     FREE : refill immediately after each accept
//     HOLD : re-present the same vector after each accept (no LCG advance)
//     STEP : wait for a step pulse after each accept before refilling
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   seed_load    pulse: load seed_val into the LCG, abort any run
//   seed_val     32-bit seed
//   start        pulse: begin a run (only honoured in IDLE or DONE)
//   cfg_cycles   vectors per run, 0 = unbounded (sampled at start)
//   cfg_mode     0 FREE, 1 HOLD, 2 STEP, 3 behaves as FREE (sampled at start)
//   step         STEP mode: permits generation of one more vector
//   bus          master side of the out_valid/out_ready/out_vec stream
//   vec_count    vectors accepted in the current run (saturating)
//   busy         a run is in progress
//   done         run budget reached; held until start, seed_load or rst
// -----------------------------------------------------------------------------
module lcg_stim_gen #(
  parameter int          OUT_W        = 260,
  parameter logic [31:0] SEED_DEFAULT = 32'hF7FD5646,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed_val,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_cycles,
  input  logic [1:0]       cfg_mode,
  input  logic             step,
  lcg_stim_gen_if.master   bus,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy,
  output logic             done
);

  // Words per vector, width of the truncated top word, word index width.
  localparam int                NW       = (OUT_W + 31) / 32;
  localparam int                LAST_W   = OUT_W - 32 * (NW - 1);
  localparam int                IDX_W    = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NW - 1);
  localparam logic [31:0]       LCG_MUL  = 32'h41C64E6D;
  localparam logic [31:0]       LCG_INC  = 32'h00003039;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PRESENT,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_STEP = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           r_fsm;
  logic [31:0]      r_lcg;
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_vec;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
  logic             r_done;
  mode_e            r_mode;
  logic [CNT_W-1:0] r_cycles;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  state_e           w_fsm_next;
  logic [31:0]      w_lcg_next;
  logic [OUT_W-1:0] w_full;
  logic             w_adv;
  logic             w_load_vec;
  logic             w_start_acc;
  logic             w_accept;
  logic             w_valid_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done_next;
  logic             w_budget_hit;

  assign w_lcg_next   = r_lcg * LCG_MUL + LCG_INC;
  assign w_accept     = r_valid & bus.out_ready;
  // Saturate instead of wrapping; only reachable with an unbounded run.
  assign w_cnt_inc    = (&r_count) ? r_count : r_count + CNT_W'(1);
  assign w_budget_hit = (r_cycles != '0) && (w_cnt_inc == r_cycles);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    w_fsm_next   = r_fsm;
    w_adv        = 1'b0;
    w_load_vec   = 1'b0;
    w_start_acc  = 1'b0;
    w_valid_next = r_valid;
    w_cnt_next   = r_count;
    w_done_next  = r_done;

    unique case (r_fsm)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_fsm_next  = S_FILL;
          w_start_acc = 1'b1;
          w_cnt_next  = '0;
          w_done_next = 1'b0;
        end
      end

      S_FILL: begin
        w_adv = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_load_vec   = 1'b1;
          w_valid_next = 1'b1;
          w_fsm_next   = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (w_accept) begin
          w_cnt_next = w_cnt_inc;
          if (w_budget_hit) begin
            w_fsm_next   = S_DONE;
            w_valid_next = 1'b0;
            w_done_next  = 1'b1;
          end else begin
            unique case (r_mode)
              MODE_HOLD: begin
                // Same vector stays on the bus; the LCG does not move.
                w_fsm_next = S_PRESENT;
              end
              MODE_STEP: begin
                w_fsm_next   = S_WAIT;
                w_valid_next = 1'b0;
              end
              default: begin
                w_fsm_next   = S_FILL;
                w_valid_next = 1'b0;
              end
            endcase
          end
        end
      end

      S_WAIT: begin
        if (step) begin
          w_fsm_next = S_FILL;
        end
      end

      default: begin
        w_fsm_next = S_IDLE;
      end
    endcase

    // Seed load overrides everything the FSM decided this cycle, including
    // a simultaneous start.
    if (seed_load) begin
      w_fsm_next   = S_IDLE;
      w_adv        = 1'b0;
      w_load_vec   = 1'b0;
      w_start_acc  = 1'b0;
      w_valid_next = 1'b0;
      w_cnt_next   = '0;
      w_done_next  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcg    <= SEED_DEFAULT;
      r_idx    <= '0;
      r_vec    <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_mode   <= MODE_FREE;
      r_cycles <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_cnt_next;
      r_done  <= w_done_next;

      if (seed_load) begin
        r_lcg <= seed_val;
      end else if (w_adv) begin
        r_lcg <= w_lcg_next;
      end

      // An aborted fill restarts from word 0.
      if (seed_load) begin
        r_idx <= '0;
      end else if (w_adv) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end

      // The visible vector only changes once the whole fill is complete.
      if (w_load_vec) begin
        r_vec <= w_full;
      end

      if (w_start_acc) begin
        r_mode   <= mode_e'(cfg_mode);
        r_cycles <= cfg_cycles;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fill buffer: holds words 0..NW-2 while the fill is in progress. The top
  // word goes straight from the LCG into r_vec, truncated to LAST_W bits.
  // ---------------------------------------------------------------------------
  generate
    if (NW > 1) begin : g_multi_word
      logic [32*(NW-1)-1:0] r_buf;

      // NOTE: the fill buffer has no reset; each word is written during FILL
      // before the vector that uses it is loaded, so reset values are never
      // observable.
      always_ff @(posedge clk) begin
        if (w_adv && (r_idx != LAST_IDX)) begin
          r_buf[32*int'(r_idx) +: 32] <= w_lcg_next;
        end
      end

      assign w_full = {w_lcg_next[LAST_W-1:0], r_buf};
    end else begin : g_single_word
      assign w_full = w_lcg_next[LAST_W-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.out_valid = r_valid;
  assign bus.out_vec   = r_vec;
  assign vec_count     = r_count;
  assign done          = r_done;
  assign busy          = (r_fsm != S_IDLE) && (r_fsm != S_DONE);

endmodule : lcg_stim_gen

// File: tb/tb_lcg_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_lcg_stim_gen
//   Directed bench for lcg_stim_gen. Two instances share clk/rst:
//   u_dut_a with OUT_W=64 (short vectors for control-path scenarios) and
//   u_dut_b with OUT_W=260 (long run against a software LCG model).
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_lcg_stim_gen;

  localparam logic [63:0] V1 = 64'hD3DC167E_00003039;  // seed 0, words 0..1

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: OUT_W = 64
  logic        a_seed_load, a_start, a_step;
  logic [31:0] a_seed_val, a_cfg_cycles, a_vec_count;
  logic [1:0]  a_cfg_mode;
  logic        a_busy, a_done;
  lcg_stim_gen_if #(.OUT_W(64)) a_if ();

  lcg_stim_gen #(.OUT_W(64)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (a_seed_load),
    .seed_val   (a_seed_val),
    .start      (a_start),
    .cfg_cycles (a_cfg_cycles),
    .cfg_mode   (a_cfg_mode),
    .step       (a_step),
    .bus        (a_if.master),
    .vec_count  (a_vec_count),
    .busy       (a_busy),
    .done       (a_done)
  );

  // DUT B: OUT_W = 260
  logic        b_seed_load, b_start, b_step;
  logic [31:0] b_seed_val, b_cfg_cycles, b_vec_count;
  logic [1:0]  b_cfg_mode;
  logic        b_busy, b_done;
  lcg_stim_gen_if #(.OUT_W(260)) b_if ();

  lcg_stim_gen #(.OUT_W(260)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (b_seed_load),
    .seed_val   (b_seed_val),
    .start      (b_start),
    .cfg_cycles (b_cfg_cycles),
    .cfg_mode   (b_cfg_mode),
    .step       (b_step),
    .bus        (b_if.master),
    .vec_count  (b_vec_count),
    .busy       (b_busy),
    .done       (b_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [31:0] lcg(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h00003039;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Load seed 0 into DUT A (one cycle).
  task automatic a_seed0();
    a_seed_val  = 32'h0;
    a_seed_load = 1'b1;
    tick();
    a_seed_load = 1'b0;
  endtask

  // Bounded wait for DUT A out_valid; an expired budget is a failure.
  task automatic a_wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (a_if.out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (a_if.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s: out_valid not seen within %0d cycles", name, budget);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", a_if.out_valid); end
    total++; if (a_if.out_vec !== 64'h0) begin bad++; $display("FAIL reset_a_vec: got %h want 0", a_if.out_vec); end
    total++; if (a_vec_count !== 32'h0) begin bad++; $display("FAIL reset_a_count: got %0d want 0", a_vec_count); end
    total++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin bad++; $display("FAIL reset_a_flags: busy=%b done=%b want 0 0", a_busy, a_done); end
    total++; if (b_if.out_valid !== 1'b0 || b_if.out_vec !== 260'h0) begin bad++; $display("FAIL reset_b_out: valid=%b vec=%h want 0 0", b_if.out_valid, b_if.out_vec); end
    total++; if (b_busy !== 1'b0 || b_done !== 1'b0 || b_vec_count !== 32'h0) begin bad++; $display("FAIL reset_b_flags: busy=%b done=%b count=%0d want 0 0 0", b_busy, b_done, b_vec_count); end
    rst = 1'b0;
    tick();
  endtask

  // Seed 0, FREE, one vector: valid exactly 3 edges after start is sampled.
  task automatic test_first_vector();
    a_seed0();
    a_cfg_cycles = 32'd1;
    a_cfg_mode   = 2'd0;
    a_if.out_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    total++; if (a_busy !== 1'b1 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL first_fill1: busy=%b valid=%b want 1 0", a_busy, a_if.out_valid); end
    tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL first_fill2: valid=%b want 0", a_if.out_valid); end
    tick();
    total++; if (a_if.out_valid !== 1'b1 || a_if.out_vec !== V1) begin bad++; $display("FAIL first_vec: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, V1); end
    tick();
    total++; if (a_done !== 1'b1 || a_vec_count !== 32'd1) begin bad++; $display("FAIL first_done: done=%b count=%0d want 1 1", a_done, a_vec_count); end
    total++; if (a_if.out_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL first_idle: valid=%b busy=%b want 0 0", a_if.out_valid, a_busy); end
  endtask

  // Default seed, 260-bit vectors, 100 back-to-back vectors vs software LCG.
  task automatic test_long_run();
    logic [31:0]  m;
    logic [287:0] exp_full;
    int           t_prev, n, gap;
    bit           timed_out;
    m = 32'hF7FD5646;
    timed_out = 1'b0;
    b_if.out_ready = 1'b1;
    b_cfg_cycles   = 32'd100;
    b_cfg_mode     = 2'd0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    t_prev = cyc;
    for (int i = 0; i < 100 && !timed_out; i++) begin
      n = 0;
      while (b_if.out_valid !== 1'b1 && n < 30) begin
        tick();
        n++;
      end
      total++;
      if (b_if.out_valid !== 1'b1) begin
        bad++;
        timed_out = 1'b1;
        $display("FAIL long_timeout: vector %0d not valid within 30 cycles", i);
      end else begin
        gap = cyc - t_prev;
        total++;
        if (gap != ((i == 0) ? 9 : 10)) begin
          bad++;
          $display("FAIL long_gap: vector %0d gap=%0d want %0d", i, gap, (i == 0) ? 9 : 10);
        end
        exp_full = '0;
        for (int k = 0; k < 9; k++) begin
          m = lcg(m);
          exp_full[32*k +: 32] = m;
        end
        total++;
        if (b_if.out_vec !== exp_full[259:0]) begin
          bad++;
          $display("FAIL long_vec: vector %0d got %h want %h", i, b_if.out_vec, exp_full[259:0]);
        end
        total++;
        if (b_if.out_vec[259:256] !== m[3:0]) begin
          bad++;
          $display("FAIL long_top: vector %0d got %h want %h", i, b_if.out_vec[259:256], m[3:0]);
        end
        t_prev = cyc;
        tick();
      end
    end
    total++;
    if (b_done !== 1'b1 || b_vec_count !== 32'd100 || b_busy !== 1'b0) begin
      bad++;
      $display("FAIL long_done: done=%b count=%0d busy=%b want 1 100 0", b_done, b_vec_count, b_busy);
    end
  endtask

  // Consumer stalls for 7 cycles: vector, valid and count must not move,
  // and the following vector continues the LCG sequence exactly.
  task automatic test_backpressure();
    logic [31:0] w2, w3;
    w2 = lcg(32'hD3DC167E);
    w3 = lcg(w2);
    a_if.out_ready = 1'b0;
    a_seed0();
    a_cfg_cycles = 32'd0;
    a_cfg_mode   = 2'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_wait_valid(10, "bp_first");
    total++; if (a_if.out_vec !== V1) begin bad++; $display("FAIL bp_vec: got %h want %h", a_if.out_vec, V1); end
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (a_if.out_valid !== 1'b1 || a_if.out_vec !== V1 || a_vec_count !== 32'd0) begin
        bad++;
        $display("FAIL bp_stall: cycle %0d valid=%b vec=%h count=%0d want 1 %h 0", i, a_if.out_valid, a_if.out_vec, a_vec_count, V1);
      end
    end
    a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0;
    total++; if (a_vec_count !== 32'd1 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_accept: count=%0d valid=%b want 1 0", a_vec_count, a_if.out_valid); end
    a_wait_valid(10, "bp_second");
    total++; if (a_if.out_vec !== {w3, w2}) begin bad++; $display("FAIL bp_next: got %h want %h", a_if.out_vec, {w3, w2}); end
    a_seed0();
    total++; if (a_busy !== 1'b0 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL bp_abort: busy=%b valid=%b want 0 0", a_busy, a_if.out_valid); end
  endtask

  // HOLD, 3 vectors: same vector accepted three times, then LCG has only
  // advanced NW times (next FREE vector is words 2..3 of the sequence).
  task automatic test_hold();
    logic [31:0] w2, w3;
    w2 = lcg(32'hD3DC167E);
    w3 = lcg(w2);
    a_if.out_ready = 1'b0;
    a_seed0();
    a_cfg_cycles = 32'd3;
    a_cfg_mode   = 2'd1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_wait_valid(10, "hold_first");
    total++; if (a_if.out_vec !== V1) begin bad++; $display("FAIL hold_vec: got %h want %h", a_if.out_vec, V1); end
    a_if.out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (a_vec_count !== 32'(i)) begin bad++; $display("FAIL hold_count: got %0d want %0d", a_vec_count, i); end
      total++;
      if (i < 3) begin
        if (a_if.out_valid !== 1'b1 || a_if.out_vec !== V1) begin bad++; $display("FAIL hold_repeat: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, V1); end
      end else begin
        if (a_done !== 1'b1 || a_if.out_valid !== 1'b0) begin bad++; $display("FAIL hold_done: done=%b valid=%b want 1 0", a_done, a_if.out_valid); end
      end
    end
    a_cfg_cycles = 32'd1;
    a_cfg_mode   = 2'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    total++; if (a_vec_count !== 32'd0 || a_done !== 1'b0) begin bad++; $display("FAIL hold_restart: count=%0d done=%b want 0 0", a_vec_count, a_done); end
    tick();
    tick();
    total++; if (a_if.out_valid !== 1'b1 || a_if.out_vec !== {w3, w2}) begin bad++; $display("FAIL hold_lcg: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, {w3, w2}); end
    tick();
  endtask

  // STEP: after the first vector nothing happens until step is pulsed.
  task automatic test_step();
    logic [31:0] w2, w3;
    w2 = lcg(32'hD3DC167E);
    w3 = lcg(w2);
    a_if.out_ready = 1'b1;
    a_seed0();
    a_cfg_cycles = 32'd0;
    a_cfg_mode   = 2'd2;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    total++; if (a_if.out_valid !== 1'b1 || a_if.out_vec !== V1) begin bad++; $display("FAIL step_first: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, V1); end
    tick();
    total++; if (a_vec_count !== 32'd1) begin bad++; $display("FAIL step_count: got %0d want 1", a_vec_count); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL step_idle: cycle %0d valid=%b want 0", i, a_if.out_valid); end
    end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL step_busy: got %b want 1", a_busy); end
    a_step = 1'b1;
    tick();
    a_step = 1'b0;
    tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL step_fill: valid=%b want 0", a_if.out_valid); end
    tick();
    total++; if (a_if.out_valid !== 1'b1 || a_if.out_vec !== {w3, w2}) begin bad++; $display("FAIL step_vec: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, {w3, w2}); end
    a_seed0();
  endtask

  // seed_load and rst mid-fill abort the vector; rerun reproduces V1.
  task automatic test_abort();
    a_if.out_ready = 1'b1;
    a_seed0();
    a_cfg_cycles = 32'd1;
    a_cfg_mode   = 2'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_seed_val  = 32'h0;
    a_seed_load = 1'b1;
    tick();
    a_seed_load = 1'b0;
    total++; if (a_if.out_valid !== 1'b0 || a_busy !== 1'b0 || a_vec_count !== 32'd0) begin bad++; $display("FAIL abort_seed: valid=%b busy=%b count=%0d want 0 0 0", a_if.out_valid, a_busy, a_vec_count); end
    tick();
    total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL abort_quiet: valid=%b want 0", a_if.out_valid); end
    a_seed_load = 1'b1;
    a_start     = 1'b1;
    tick();
    a_seed_load = 1'b0;
    a_start     = 1'b0;
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL abort_seed_start: busy=%b want 0", a_busy); end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    total++; if (a_if.out_valid !== 1'b1 || a_if.out_vec !== V1) begin bad++; $display("FAIL abort_rerun: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, V1); end
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (a_if.out_valid !== 1'b0 || a_if.out_vec !== 64'h0) begin bad++; $display("FAIL abort_rst_out: valid=%b vec=%h want 0 0", a_if.out_valid, a_if.out_vec); end
    total++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_vec_count !== 32'd0) begin bad++; $display("FAIL abort_rst_flags: busy=%b done=%b count=%0d want 0 0 0", a_busy, a_done, a_vec_count); end
    a_seed0();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    total++; if (a_if.out_valid !== 1'b1 || a_if.out_vec !== V1) begin bad++; $display("FAIL abort_rst_rerun: valid=%b vec=%h want 1 %h", a_if.out_valid, a_if.out_vec, V1); end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    a_seed_load = 1'b0; a_start = 1'b0; a_step = 1'b0;
    a_seed_val = 32'h0; a_cfg_cycles = 32'h0; a_cfg_mode = 2'd0;
    a_if.out_ready = 1'b0;
    b_seed_load = 1'b0; b_start = 1'b0; b_step = 1'b0;
    b_seed_val = 32'h0; b_cfg_cycles = 32'h0; b_cfg_mode = 2'd0;
    b_if.out_ready = 1'b0;

    test_reset();
    test_first_vector();
    test_long_run();
    test_backpressure();
    test_hold();
    test_step();
    test_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_lcg_stim_gen
